// File: rtl/xc_malu_iter.sv
// xc_malu_iter : iterative multiply / divide unit, W-bit operands, UNROLL bits per cycle.
//
// Ports
//   clock, resetn          system clock, asynchronous active-low reset
//   rs1, rs2   [W-1:0]     operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   flush                  abandon current op or release the result; back to IDLE
//   valid                  operands and uop valid, held stable until ready & flush
//   uop_*                  one-hot operation select (mul, mulu, mulsu, clmul, div, divu, rem, remu)
//   result     [2W-1:0]    mul: {hi,lo}; div/rem: {W'b0, q or r}
//   ready                  result valid, held until flush
//
// Optional feature macro: XC_MALU_ITER_EARLY_EXIT_EN
//   When defined, a zero rs2 at the accept edge skips straight to DONE (not constant time).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for valid; latches operand magnitudes and signs
// RUN   | N = W/UNROLL iteration cycles (shift-add / xor / subtract)
// FIX   | sign correction and div-by-zero quotient, result registered
// DONE  | ready high, result stable until flush
module xc_malu_iter #(
    parameter int W      = 32,
    parameter int UNROLL = 1
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic [W-1:0]   rs1,
    input  logic [W-1:0]   rs2,
    input  logic           flush,
    input  logic           valid,
    input  logic           uop_mul,
    input  logic           uop_mulu,
    input  logic           uop_mulsu,
    input  logic           uop_clmul,
    input  logic           uop_div,
    input  logic           uop_divu,
    input  logic           uop_rem,
    input  logic           uop_remu,
    output logic [2*W-1:0] result,
    output logic           ready
);
    localparam int N  = W / UNROLL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   m;        // multiplicand (mul) or divisor (div) magnitude
    logic [2*W-1:0] acc;      // {hi,lo}: product window, or {remainder, quotient}
    logic           op_div, op_rem, op_clmul;
    logic           neg_res, neg_rem, div_zero;

    logic           sel_div, any_uop, a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag;

    assign sel_div = uop_div | uop_divu | uop_rem | uop_remu;
    assign any_uop = uop_mul | uop_mulu | uop_mulsu | uop_clmul | sel_div;
    assign a_neg   = rs1[W-1] & (uop_mul | uop_mulsu | uop_div | uop_rem);
    assign b_neg   = rs2[W-1] & (uop_mul | uop_div | uop_rem);
    assign a_mag   = a_neg ? -rs1 : rs1;
    assign b_mag   = b_neg ? -rs2 : rs2;

    // UNROLL iteration steps per cycle.
    logic [2*W-1:0] nxt;
    logic [W-1:0]   st_hi, st_lo, st_t;
    logic [W:0]     st_sh, st_diff, st_s;

    always_comb begin
        nxt     = acc;
        st_hi   = '0;
        st_lo   = '0;
        st_t    = '0;
        st_sh   = '0;
        st_diff = '0;
        st_s    = '0;
        for (int i = 0; i < UNROLL; i++) begin
            st_hi = nxt[2*W-1:W];
            st_lo = nxt[W-1:0];
            if (op_div) begin
                // Restoring divide: remainder stays below the divisor, so the
                // top bit of the difference is a clean borrow flag.
                st_sh   = {st_hi, st_lo[W-1]};
                st_diff = st_sh - {1'b0, m};
                if (!st_diff[W])
                    nxt = {st_diff[W-1:0], st_lo[W-2:0], 1'b1};
                else
                    nxt = {st_sh[W-1:0], st_lo[W-2:0], 1'b0};
            end else if (op_clmul) begin
                st_t = st_lo[0] ? (st_hi ^ m) : st_hi;
                nxt  = {1'b0, st_t, st_lo[W-1:1]};
            end else begin
                st_s = {1'b0, st_hi} + (st_lo[0] ? {1'b0, m} : {(W+1){1'b0}});
                nxt  = {st_s, st_lo[W-1:1]};
            end
        end
    end

    // Sign fix-up. The -2^(W-1)/-1 case falls out naturally: the magnitudes give
    // q = 2^(W-1) (== rs1) with no negation and r = 0.
    logic [W-1:0]   fix_q, fix_r;
    logic [2*W-1:0] fix_val;

    always_comb begin
        fix_q = neg_res ? -acc[W-1:0] : acc[W-1:0];
        if (div_zero)
            fix_q = '1;
        fix_r = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
        if (op_div)
            fix_val = {{W{1'b0}}, op_rem ? fix_r : fix_q};
        else
            fix_val = neg_res ? -acc : acc;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            m        <= '0;
            acc      <= '0;
            op_div   <= 1'b0;
            op_rem   <= 1'b0;
            op_clmul <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            result   <= '0;
            ready    <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        cnt      <= '0;
                        op_div   <= sel_div;
                        op_rem   <= uop_rem | uop_remu;
                        op_clmul <= uop_clmul;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= (rs2 == '0);
                        if (!any_uop) begin
                            state  <= S_DONE;
                            result <= '0;
                        end
`ifdef XC_MALU_ITER_EARLY_EXIT_EN
                        else if (rs2 == '0) begin
                            state  <= S_DONE;
                            result <= sel_div ? {{W{1'b0}}, (uop_rem | uop_remu) ? rs1 : {W{1'b1}}}
                                              : {(2*W){1'b0}};
                        end
`endif
                        else begin
                            state <= S_RUN;
                            m     <= sel_div ? b_mag : a_mag;
                            acc   <= {{W{1'b0}}, sel_div ? a_mag : b_mag};
                        end
                    end
                end
                S_RUN: begin
                    acc <= nxt;
                    if (cnt == CW'(N - 1)) begin
                        cnt   <= '0;
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    result <= fix_val;
                    ready  <= 1'b1;
                    state  <= S_DONE;
                end
                default: begin
                    // Direct IDLE->DONE entries raise ready one cycle after accept.
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_xc_malu_iter.sv
module tb_xc_malu_iter;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        flush = 1'b0, valid = 1'b0;
    logic [7:0]  uops = '0;
    logic [63:0] res0, res2;
    logic [31:0] res1;
    logic [2:0]  rdy;

    int vectors = 0;
    int miscompares = 0;
    int lat[3];

    always #5 clock = ~clock;

    xc_malu_iter #(.W(32), .UNROLL(1)) d0 (
        .clock(clock), .resetn(resetn), .rs1(rs1), .rs2(rs2), .flush(flush), .valid(valid),
        .uop_mul(uops[0]), .uop_mulu(uops[1]), .uop_mulsu(uops[2]), .uop_clmul(uops[3]),
        .uop_div(uops[4]), .uop_divu(uops[5]), .uop_rem(uops[6]), .uop_remu(uops[7]),
        .result(res0), .ready(rdy[0]));

    xc_malu_iter #(.W(16), .UNROLL(2)) d1 (
        .clock(clock), .resetn(resetn), .rs1(rs1[15:0]), .rs2(rs2[15:0]), .flush(flush), .valid(valid),
        .uop_mul(uops[0]), .uop_mulu(uops[1]), .uop_mulsu(uops[2]), .uop_clmul(uops[3]),
        .uop_div(uops[4]), .uop_divu(uops[5]), .uop_rem(uops[6]), .uop_remu(uops[7]),
        .result(res1), .ready(rdy[1]));

    xc_malu_iter #(.W(32), .UNROLL(4)) d2 (
        .clock(clock), .resetn(resetn), .rs1(rs1), .rs2(rs2), .flush(flush), .valid(valid),
        .uop_mul(uops[0]), .uop_mulu(uops[1]), .uop_mulsu(uops[2]), .uop_clmul(uops[3]),
        .uop_div(uops[4]), .uop_divu(uops[5]), .uop_rem(uops[6]), .uop_remu(uops[7]),
        .result(res2), .ready(rdy[2]));

    function automatic int dw(int i);
        return (i == 1) ? 16 : 32;
    endfunction

    function automatic int dn(int i);
        return (i == 0) ? 32 : 8;
    endfunction

    function automatic logic [63:0] get_res(int i);
        case (i)
            0: return res0;
            1: return {32'b0, res1};
            default: return res2;
        endcase
    endfunction

    // Reference: op 0..7 = mul, mulu, mulsu, clmul, div, divu, rem, remu; 8 = no uop.
    function automatic logic [63:0] model(int w, int op, logic [31:0] a_in, logic [31:0] b_in);
        logic [63:0] m1, m2, ua, ub, res;
        longint sa, sb, q, r, lim;
        m1  = (w == 32) ? 64'hFFFF_FFFF : 64'hFFFF;
        m2  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        ua  = {32'b0, a_in} & m1;
        ub  = {32'b0, b_in} & m1;
        sa  = ua[w-1] ? longint'(ua) - longint'(m1) - 1 : longint'(ua);
        sb  = ub[w-1] ? longint'(ub) - longint'(m1) - 1 : longint'(ub);
        lim = -(longint'(1) << (w - 1));
        res = '0;
        case (op)
            0: res = 64'(sa * sb) & m2;
            1: res = (ua * ub) & m2;
            2: res = 64'(sa * longint'(ub)) & m2;
            3: begin
                for (int i = 0; i < w; i++)
                    if (ub[i]) res = res ^ (ua << i);
                res = res & m2;
            end
            4, 6: begin
                if (ub == 0) begin q = -1; r = sa; end
                else if (sa == lim && sb == -1) begin q = sa; r = 0; end
                else begin q = sa / sb; r = sa % sb; end
                res = 64'((op == 4) ? q : r) & m1;
            end
            5, 7: begin
                if (ub == 0) res = (op == 5) ? m1 : ua;
                else         res = (op == 5) ? (ua / ub) : (ua % ub);
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic int exp_lat(int i, logic [31:0] b);
        int l;
        l = dn(i) + 1;
`ifdef XC_MALU_ITER_EARLY_EXIT_EN
        if (((dw(i) == 16) ? {16'b0, b[15:0]} : b) == 32'b0) l = 1;
`endif
        return l;
    endfunction

    // Returns just after the accept edge.
    task automatic start_op(int op, logic [31:0] a, logic [31:0] b);
        @(negedge clock);
        rs1   = a;
        rs2   = b;
        uops  = (op < 8) ? 8'(1 << op) : 8'h00;
        valid = 1'b1;
        flush = 1'b0;
        @(posedge clock);
    endtask

    task automatic wait_ready();
        bit all;
        for (int i = 0; i < 3; i++) lat[i] = -1;
        #1;
        for (int c = 0; c < 300; c++) begin
            all = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (lat[i] < 0 && rdy[i]) lat[i] = c;
                if (lat[i] < 0) all = 1'b0;
            end
            if (all) break;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_flush(string name);
        @(negedge clock);
        valid = 1'b0;
        uops  = '0;
        flush = 1'b1;
        @(posedge clock);
        #1;
        vectors++;
        if (rdy !== 3'b000) begin
            miscompares++;
            $display("FAIL %s ready-after-flush got %b want 000", name, rdy);
        end
        @(negedge clock);
        flush = 1'b0;
    endtask

    task automatic check_op(string name, int op, logic [31:0] a, logic [31:0] b,
                            bit use_exp, logic [63:0] exp0);
        logic [63:0] want;
        start_op(op, a, b);
        wait_ready();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (lat[i] < 0) begin
                miscompares++;
                $display("FAIL %s dut%0d ready timeout got none want %0d", name, i, exp_lat(i, b));
                continue;
            end
            if (op != 8 && lat[i] != exp_lat(i, b)) begin
                miscompares++;
                $display("FAIL %s dut%0d latency got %0d want %0d", name, i, lat[i], exp_lat(i, b));
            end
            vectors++;
            want = model(dw(i), op, a, b);
            if (get_res(i) !== want) begin
                miscompares++;
                $display("FAIL %s dut%0d op%0d a=%h b=%h result got %h want %h",
                         name, i, op, a, b, get_res(i), want);
            end
        end
        if (use_exp) begin
            vectors++;
            if (res0 !== exp0) begin
                miscompares++;
                $display("FAIL %s dut0 const result got %h want %h", name, res0, exp0);
            end
        end
        do_flush(name);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        vectors++;
        if (rdy !== 3'b000 || res0 !== 64'b0 || res1 !== 32'b0 || res2 !== 64'b0) begin
            miscompares++;
            $display("FAIL reset ready=%b r0=%h r1=%h r2=%h want all 0", rdy, res0, res1, res2);
        end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_directed();
        check_op("mul_ff_3",   0, 32'hFFFF_FFFF, 32'h3,         1, 64'hFFFF_FFFF_FFFF_FFFD);
        check_op("divu_100_7", 5, 32'd100,       32'd7,         1, 64'h0E);
        check_op("remu_100_7", 7, 32'd100,       32'd7,         1, 64'h02);
        check_op("div_ovf",    4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 64'h0000_0000_8000_0000);
        check_op("rem_ovf",    6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 64'h0);
        check_op("div_5_0",    4, 32'd5,         32'd0,         1, 64'h0000_0000_FFFF_FFFF);
        check_op("rem_5_0",    6, 32'd5,         32'd0,         1, 64'h05);
        check_op("clmul_3_3",  3, 32'h3,         32'h3,         1, 64'h5);
        check_op("mulsu_ff",   2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFF_0000_0001);
        check_op("div_neg",    4, 32'hFFFF_FFF9, 32'd2,         1, 64'h0000_0000_FFFF_FFFD);
        check_op("rem_neg",    6, 32'hFFFF_FFF9, 32'd2,         1, 64'h0000_0000_FFFF_FFFF);
        check_op("no_uop",     8, 32'h1234_5678, 32'h9,         1, 64'h0);
    endtask

    task automatic test_flush_mid();
        logic [63:0] held;
        bit          seen;
        check_op("pre_flush", 1, 32'h0001_0001, 32'h0000_0003, 1, 64'h3_0003);
        held = res0;
        start_op(0, 32'h1357_9BDF, 32'h2468_ACE0);
        repeat (10) @(posedge clock);
        @(negedge clock);
        valid = 1'b0;
        uops  = '0;
        flush = 1'b1;
        @(posedge clock);
        #1;
        vectors++;
        if (rdy !== 3'b000 || res0 !== held) begin
            miscompares++;
            $display("FAIL flush_mid ready=%b res0=%h want 000 and %h", rdy, res0, held);
        end
        @(negedge clock);
        flush = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (rdy !== 3'b000) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL flush_idle ready rose got 1 want 0");
        end
        check_op("mulu_7_6", 1, 32'd7, 32'd6, 1, 64'd42);
    endtask

    task automatic test_reset_mid();
        start_op(1, 32'hDEAD_BEEF, 32'h0000_0101);
        repeat (5) @(posedge clock);
        #2;
        resetn = 1'b0;
        valid  = 1'b0;
        uops   = '0;
        #1;
        vectors++;
        if (rdy !== 3'b000 || res0 !== 64'b0 || res1 !== 32'b0 || res2 !== 64'b0) begin
            miscompares++;
            $display("FAIL reset_mid ready=%b r0=%h r1=%h r2=%h want all 0", rdy, res0, res1, res2);
        end
        @(negedge clock);
        resetn = 1'b1;
        check_op("after_reset", 0, 32'hFFFF_FFFE, 32'h0000_0005, 1, 64'hFFFF_FFFF_FFFF_FFF6);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_8000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        int          op, r;
        logic [31:0] a, b;
        for (int it = 0; it < 150; it++) begin
            r  = $urandom_range(0, 19);
            op = (r < 18) ? (r % 8) : 8;
            a  = rnd_operand();
            b  = rnd_operand();
            repeat ($urandom_range(0, 3)) @(posedge clock);
            if ($urandom_range(0, 7) == 0) begin
                start_op(op, a, b);
                repeat ($urandom_range(0, 40)) @(posedge clock);
                do_flush("rand_abort");
            end
            check_op("random", op, a, b, 0, 64'h0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush_mid();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
